// File: rtl/reg_pwm_timer.sv
// reg_pwm_timer: register-programmed PWM timer fed by the SPI register wrapper.
//
// All host control arrives on the flat config bus. All observation leaves on
// the flat status bus. The block also drives one registered PWM pin.
//
// Ports:
//   clk          single clock
//   rstb         synchronous active-low reset
//   ena          clock enable; when low every register holds its value
//   config_regs  flat config bus, reg n at [n*REG_WIDTH +: REG_WIDTH]
//                  cfg0 CTRL  : bit0 EN, bit1 ONESHOT, bit2 INV, bit3 CLR (rising edge)
//                  cfg1 PRESC : tick every PRESC+1 clocks (read live)
//                  cfg2 PERIOD: counter runs 0..PERIOD (shadowed)
//                  cfg3 DUTY  : compare value (shadowed)
//   status_regs  flat status bus, same packing
//                  st0 counter, st1 wrap count, st2 flags, st3 block ID 0xA1
//                  st2 flags  : bit0 RUNNING, bit1 pwm_out, bit2 WRAP_STICKY,
//                               bit3 DONE_STICKY, bit4 WCNT_OVF_STICKY
//   pwm_out      registered PWM output
//
// Build option: define REG_PWM_TIMER_WRAP_COUNT_EN to implement the wrap
// counter (st1) and WCNT_OVF_STICKY. Without it, both read as zero.
//
// Handshake: there is none. Config is level-sampled every enabled clock and
// status is a continuous register view; only CLR is edge-qualified.

module reg_pwm_timer #(
  parameter int NUM_CFG    = 8,
  parameter int NUM_STATUS = 8,
  parameter int REG_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            ena,
  input  logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  output logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
  output logic                            pwm_out
);

  localparam int W = REG_WIDTH;
  localparam logic [W-1:0] BLOCK_ID = W'(8'hA1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   counter;
  logic [W-1:0]   presc_cnt;
  logic [W-1:0]   period_s;
  logic [W-1:0]   duty_s;
  logic           wrap_sticky;
  logic           done_sticky;
  logic           clr_q;
  logic [W-1:0]   wcnt;
  logic           ovf_sticky;

  // Config decode
  logic           en;
  logic           oneshot;
  logic           inv;
  logic           clr_bit;
  logic [W-1:0]   presc;
  logic [W-1:0]   period;
  logic [W-1:0]   duty;

  assign en      = config_regs[0];
  assign oneshot = config_regs[1];
  assign inv     = config_regs[2];
  assign clr_bit = config_regs[3];
  assign presc   = config_regs[1*W +: W];
  assign period  = config_regs[2*W +: W];
  assign duty    = config_regs[3*W +: W];

  // Reserved CTRL bits and cfg4+ are intentionally ignored.
  logic unused_cfg;
  assign unused_cfg = ^config_regs;

  logic tick;
  logic wrap;
  logic clr_rise;
  logic pwm_raw;

  // A tick only happens while RUN stays enabled; an EN drop wins over counting.
  assign tick     = (state == ST_RUN) && en && (presc_cnt == presc);
  assign wrap     = tick && (counter == period_s);
  assign clr_rise = clr_bit && !clr_q;
  assign pwm_raw  = (state == ST_RUN) && (counter < duty_s);

  // Main FSM, counting datapath and sticky flags
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state       <= ST_IDLE;
      counter     <= '0;
      presc_cnt   <= '0;
      period_s    <= '0;
      duty_s      <= '0;
      wrap_sticky <= 1'b0;
      done_sticky <= 1'b0;
      clr_q       <= 1'b0;
      pwm_out     <= 1'b0;
    end else if (ena) begin
      clr_q   <= clr_bit;
      pwm_out <= pwm_raw ^ inv;

      // Set events take priority over a coincident CLR edge.
      if (wrap)          wrap_sticky <= 1'b1;
      else if (clr_rise) wrap_sticky <= 1'b0;

      if (wrap && oneshot) done_sticky <= 1'b1;
      else if (clr_rise)   done_sticky <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (en) begin
            state     <= ST_RUN;
            counter   <= '0;
            presc_cnt <= '0;
            period_s  <= period;
            duty_s    <= duty;
          end
        end
        ST_RUN: begin
          if (!en) begin
            state     <= ST_IDLE;
            counter   <= '0;
            presc_cnt <= '0;
          end else if (tick) begin
            presc_cnt <= '0;
            if (counter == period_s) begin
              // Shadows reload only here so the output never glitches mid-period.
              counter  <= '0;
              period_s <= period;
              duty_s   <= duty;
              if (oneshot) state <= ST_DONE;
            end else begin
              counter <= counter + W'(1);
            end
          end else begin
            presc_cnt <= presc_cnt + W'(1);
          end
        end
        ST_DONE: begin
          // Counter holds; a restart needs EN to drop first.
          if (!en) begin
            state     <= ST_IDLE;
            counter   <= '0;
            presc_cnt <= '0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          counter   <= '0;
          presc_cnt <= '0;
        end
      endcase
    end
  end

`ifdef REG_PWM_TIMER_WRAP_COUNT_EN
  // A wrap coinciding with a CLR edge counts from zero, so the count reads 1.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      wcnt       <= '0;
      ovf_sticky <= 1'b0;
    end else if (ena) begin
      if (wrap)          wcnt <= (clr_rise ? '0 : wcnt) + W'(1);
      else if (clr_rise) wcnt <= '0;

      if (wrap && !clr_rise && (wcnt == '1)) ovf_sticky <= 1'b1;
      else if (clr_rise)                     ovf_sticky <= 1'b0;
    end
  end
`else
  assign wcnt       = '0;
  assign ovf_sticky = 1'b0;
`endif

  // Status view, straight from registers
  logic [W-1:0] flags;

  always_comb begin
    flags    = '0;
    flags[0] = (state == ST_RUN);
    flags[1] = pwm_out;
    flags[2] = wrap_sticky;
    flags[3] = done_sticky;
    flags[4] = ovf_sticky;

    status_regs          = '0;
    status_regs[0*W +: W] = counter;
    status_regs[1*W +: W] = wcnt;
    status_regs[2*W +: W] = flags;
    status_regs[3*W +: W] = BLOCK_ID;
  end

endmodule

// File: tb/tb_reg_pwm_timer.sv
// tb_reg_pwm_timer: directed self-checking bench for reg_pwm_timer.
//
// Expected pwm_out / st0 per cycle are generated from the period, prescaler
// and duty formulas and queued before the DUT runs; each clock pops one entry.
// Status flags and wrap counts are checked against hand-derived constants.

module tb_reg_pwm_timer;

`ifdef REG_PWM_TIMER_WRAP_COUNT_EN
  localparam bit WC = 1'b1;
`else
  localparam bit WC = 1'b0;
`endif

  // Clock / reset
  logic        clk;
  logic        rstb;
  logic        ena;
  logic [63:0] config_regs;
  logic [63:0] status_regs;
  logic        pwm_out;
  logic [7:0]  cfg [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    config_regs = '0;
    for (int i = 0; i < 8; i++) config_regs[i*8 +: 8] = cfg[i];
  end

  reg_pwm_timer #(
    .NUM_CFG(8),
    .NUM_STATUS(8),
    .REG_WIDTH(8)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .ena(ena),
    .config_regs(config_regs),
    .status_regs(status_regs),
    .pwm_out(pwm_out)
  );

  // Scoreboard: {counter[7:0], 7'b0, pwm}
  logic [15:0] exp_q[$];
  logic [7:0]  exp_wcnt;
  int          n_checks;
  int          n_errors;

  function automatic logic [7:0] st(input int n);
    return status_regs[n*8 +: 8];
  endfunction

  function automatic logic [7:0] exp_st1();
    return WC ? exp_wcnt : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full PWM period measured from the edge that started it.
  task automatic push_period(input int presc, input int period, input int duty, input bit inv);
    int len;
    int cnt;
    int prev;
    logic [7:0] cnt8;
    logic pwm;
    len = (period + 1) * (presc + 1);
    for (int t = 1; t <= len; t++) begin
      cnt  = (t / (presc + 1)) % (period + 1);
      prev = ((t - 1) / (presc + 1)) % (period + 1);
      pwm  = (prev < duty) ^ inv;
      cnt8 = cnt[7:0];
      exp_q.push_back({cnt8, 7'b0, pwm});
    end
    exp_wcnt = exp_wcnt + 8'd1;
  endtask

  task automatic push_done(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(16'h0000);
  endtask

  task automatic pop_n(input int n, input string tag);
    logic [15:0] item;
    for (int i = 0; i < n; i++) begin
      step();
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL %s_empty: observed=no entry expected=queued entry", tag);
      end else begin
        item = exp_q.pop_front();
        check({tag, "_pwm"}, {15'b0, pwm_out}, {15'b0, item[0]});
        check({tag, "_st0"}, {8'b0, st(0)}, {8'b0, item[15:8]});
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_wcnt = 8'h00;
    rstb = 1'b0;
    ena  = 1'b1;
    for (int i = 0; i < 8; i++) cfg[i] = 8'h00;
    repeat (3) step();

    // Reset state
    check("rst_st0", {8'b0, st(0)}, 16'h0000);
    check("rst_st1", {8'b0, st(1)}, 16'h0000);
    check("rst_st2", {8'b0, st(2)}, 16'h0000);
    check("rst_st3", {8'b0, st(3)}, 16'h00A1);
    for (int i = 4; i < 8; i++) check("rst_sthi", {8'b0, st(i)}, 16'h0000);
    check("rst_pwm", {15'b0, pwm_out}, 16'h0000);
    rstb = 1'b1;
    step();

    // Basic PWM: 3 high / 7 low
    cfg[1] = 8'd0; cfg[2] = 8'd9; cfg[3] = 8'd3; cfg[0] = 8'h01;
    step();
    repeat (3) push_period(0, 9, 3, 1'b0);
    pop_n(30, "basic");
    check("basic_st1", {8'b0, st(1)}, {8'b0, exp_st1()});
    check("basic_st2", {8'b0, st(2)}, 16'h0005);
    cfg[0] = 8'h00;
    step();
    step();
    check("basic_off_st2", {8'b0, st(2)}, 16'h0004);
    check("basic_off_st0", {8'b0, st(0)}, 16'h0000);
    check("basic_off_pwm", {15'b0, pwm_out}, 16'h0000);

    // Prescaler plus INV: 20-cycle period, low 8 / high 12
    cfg[1] = 8'd3; cfg[2] = 8'd4; cfg[3] = 8'd2; cfg[0] = 8'h05;
    step();
    repeat (2) push_period(3, 4, 2, 1'b1);
    pop_n(40, "presc_inv");
    check("presc_st1", {8'b0, st(1)}, {8'b0, exp_st1()});
    cfg[0] = 8'h04;
    step();
    check("inv_off_st2", {8'b0, st(2)}, 16'h0004);
    step();
    check("inv_idle_pwm", {15'b0, pwm_out}, 16'h0001);
    cfg[0] = 8'h00;
    step();
    step();
    check("inv_clear_pwm", {15'b0, pwm_out}, 16'h0000);

    // Shadowing: DUTY 3 -> 8 mid-period, then 8 -> 12 (always active)
    cfg[1] = 8'd0; cfg[2] = 8'd9; cfg[3] = 8'd3; cfg[0] = 8'h01;
    step();
    push_period(0, 9, 3, 1'b0);
    push_period(0, 9, 8, 1'b0);
    pop_n(5, "shadow_a");
    cfg[3] = 8'd8;
    pop_n(15, "shadow_b");
    push_period(0, 9, 8, 1'b0);
    push_period(0, 9, 12, 1'b0);
    push_period(0, 9, 12, 1'b0);
    pop_n(4, "shadow_c");
    cfg[3] = 8'd12;
    pop_n(26, "shadow_d");
    check("shadow_st1", {8'b0, st(1)}, {8'b0, exp_st1()});
    cfg[0] = 8'h00;
    step();
    step();

    // CLR while idle
    cfg[0] = 8'h08;
    step();
    exp_wcnt = 8'h00;
    check("clr_idle_st1", {8'b0, st(1)}, 16'h0000);
    check("clr_idle_st2", {8'b0, st(2)}, 16'h0000);
    cfg[0] = 8'h00;
    step();

    // One-shot: one 5-cycle period then DONE holds
    cfg[1] = 8'd0; cfg[2] = 8'd4; cfg[3] = 8'd2; cfg[0] = 8'h03;
    step();
    push_period(0, 4, 2, 1'b0);
    push_done(4);
    pop_n(9, "oneshot_a");
    check("oneshot_a_st2", {8'b0, st(2)}, 16'h000C);
    check("oneshot_a_st1", {8'b0, st(1)}, {8'b0, exp_st1()});
    cfg[0] = 8'h02;
    step();
    cfg[0] = 8'h03;
    step();
    push_period(0, 4, 2, 1'b0);
    push_done(4);
    pop_n(9, "oneshot_b");
    check("oneshot_b_st2", {8'b0, st(2)}, 16'h000C);
    check("oneshot_b_st1", {8'b0, st(1)}, {8'b0, exp_st1()});
    cfg[0] = 8'h00;
    step();
    step();

    // Wrap-count overflow with PERIOD=0 (wrap on every tick)
    cfg[0] = 8'h08;
    step();
    exp_wcnt = 8'h00;
    cfg[0] = 8'h00;
    step();
    check("ovf_pre_st2", {8'b0, st(2)}, 16'h0000);
    cfg[1] = 8'd0; cfg[2] = 8'd0; cfg[3] = 8'd0; cfg[0] = 8'h01;
    step();
    repeat (256) push_period(0, 0, 0, 1'b0);
    pop_n(255, "ovf_a");
    check("ovf_255_st1", {8'b0, st(1)}, WC ? 16'h00FF : 16'h0000);
    check("ovf_255_st2", {8'b0, st(2)}, 16'h0005);
    pop_n(1, "ovf_b");
    check("ovf_256_st1", {8'b0, st(1)}, {8'b0, exp_st1()});
    check("ovf_256_st2", {8'b0, st(2)}, WC ? 16'h0015 : 16'h0005);

    // CLR edge while running; slow ticks keep the wrap off the CLR cycle
    cfg[1] = 8'd3;
    step();
    cfg[0] = 8'h09;
    step();
    exp_wcnt = 8'h00;
    check("clr_run_st1", {8'b0, st(1)}, 16'h0000);
    check("clr_run_st2", {8'b0, st(2)}, 16'h0001);
    step();
    check("clr_hold_st2", {8'b0, st(2)}, 16'h0001);
    step();
    exp_wcnt = exp_wcnt + 8'd1;
    check("clr_wrap_st2", {8'b0, st(2)}, 16'h0005);
    check("clr_wrap_st1", {8'b0, st(1)}, {8'b0, exp_st1()});
    step();
    check("clr_level_st2", {8'b0, st(2)}, 16'h0005);
    cfg[0] = 8'h00;
    step();
    step();

    // ena=0 freezes everything
    cfg[1] = 8'd0; cfg[2] = 8'd9; cfg[3] = 8'd3; cfg[0] = 8'h01;
    step();
    repeat (3) step();
    check("frz_pre_st0", {8'b0, st(0)}, 16'h0003);
    check("frz_pre_pwm", {15'b0, pwm_out}, 16'h0001);
    ena = 1'b0;
    repeat (4) step();
    check("frz_st0", {8'b0, st(0)}, 16'h0003);
    check("frz_pwm", {15'b0, pwm_out}, 16'h0001);
    ena = 1'b1;
    step();
    check("frz_post_st0", {8'b0, st(0)}, 16'h0004);
    check("frz_post_pwm", {15'b0, pwm_out}, 16'h0000);

    // Reset mid-operation
    rstb = 1'b0;
    step();
    check("midrst_st0", {8'b0, st(0)}, 16'h0000);
    check("midrst_st1", {8'b0, st(1)}, 16'h0000);
    check("midrst_st2", {8'b0, st(2)}, 16'h0000);
    check("midrst_pwm", {15'b0, pwm_out}, 16'h0000);
    rstb = 1'b1;
    for (int i = 0; i < 8; i++) cfg[i] = 8'h00;
    step();

    // Final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
